uart_tx_drain: RTL
==================

Name: uart_tx_drain

Overview:
- Serial transmitter that sits directly downstream of the byte FIFO and drains it onto a UART TX line: 8N1 framing, LSB first.
- Pops one byte whenever the FIFO is non-empty, the transmitter is idle and `enable` is high.
- Drives the board TX pin.
- Obeys the FIFO pop contract:
  - `data_out` is valid in the pop cycle.
  - `empty` and `data_out` update only afterwards.
  - No pops in consecutive cycles.

Parameters:
- CLKS_PER_BIT, 1250, clock cycles per UART bit (12 MHz / 9600 baud). Must be ≥ 2.
- CNTW, $clog2(CLKS_PER_BIT), width of the bit-time counter (derived, localparam).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset), sampled on the rising edge of clk.
- enable  in  1  1 = allowed to start a new frame; a frame already in progress always completes.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  8  FIFO front element, valid whenever fifo_empty == 0.
- fifo_pop  out  1  pop_front request to the FIFO; combinational.
- tx  out  1  UART serial output; idle high; registered.
- busy  out  1  1 while a frame (start, data or stop bit) is on the line; registered.

Behaviour:
- Reset (rst == 0 at an edge):
  - state = IDLE, tx = 1, busy = 0, bit counter = 0, bit index = 0, shift register = 0.
  - While rst == 0, fifo_pop = 0.
- States: IDLE, START, DATA, STOP.
- fifo_pop = rst & enable & !fifo_empty & (state == IDLE). It is high for exactly one cycle per byte.
- IDLE with fifo_pop == 1, at the edge:
  - shift <= fifo_data.
  - tx <= 0, busy <= 1, cnt <= 0, state <= START.
  - The byte counts as consumed from this edge.
- START: cnt counts 0..CLKS_PER_BIT-1. At the edge where cnt == CLKS_PER_BIT-1:
  - tx <= shift[0], cnt <= 0, idx <= 0, state <= DATA.
- DATA, at the edge where cnt == CLKS_PER_BIT-1:
  - if idx < 7: idx <= idx + 1, tx <= shift[idx+1], cnt <= 0.
  - if idx == 7: tx <= 1, cnt <= 0, state <= STOP.
- STOP, at the edge where cnt == CLKS_PER_BIT-1: state <= IDLE, busy <= 0; tx stays 1.
- Otherwise in START, DATA and STOP: cnt <= cnt + 1, tx held. cnt never exceeds CLKS_PER_BIT-1 (no wrap).
- Timing:
  - Every line level lasts exactly CLKS_PER_BIT cycles; frame length = 10*CLKS_PER_BIT cycles.
  - With the FIFO continuously non-empty and enable = 1, consecutive start-bit falling edges are 10*CLKS_PER_BIT + 1 cycles apart (one IDLE cycle between frames).
  - Latency: tx falls on the edge ending the first cycle in which IDLE, enable = 1 and fifo_empty = 0 all hold.
- Pop contract:
  - Pops are separated by at least 10*CLKS_PER_BIT cycles, so the no-consecutive-pop rule and the FIFO's one-cycle data_out refresh are always satisfied.
  - fifo_data is never sampled outside a pop cycle.
- FIFO empty: the block remains in IDLE with tx = 1 and fifo_pop = 0. There is no underflow path.
- enable dropped mid-frame: the current frame completes normally, then the block waits in IDLE.
- Reset mid-frame:
  - tx returns to 1 at that edge; the partial frame is abandoned.
  - The popped byte is lost and is not re-popped.
- fifo_data changing outside a pop cycle is ignored; the frame uses the latched shift register only.

Test Plan (CLKS_PER_BIT = 4 unless noted):
- Reset, then hold rst = 1 with fifo_empty = 1 for 100 cycles -> tx = 1, busy = 0, fifo_pop = 0 throughout.
- Single byte 0xA5, fifo_empty = 0 for one pop:
  - fifo_pop high for exactly 1 cycle.
  - tx sampled each 4-cycle bit = 0, 1,0,1,0,0,1,0,1, 1.
  - busy high for exactly 40 cycles.
- Three queued bytes 0x00, 0xFF, 0x3C with enable = 1 -> three correct frames; start-bit falling edges 41 cycles apart; exactly 3 pop pulses, never in adjacent cycles.
- enable = 0 with FIFO non-empty -> no pop and tx = 1. Raise enable -> pop on the same cycle, tx = 0 at the next edge. Drop enable during bit 3 -> the frame finishes and no further pop occurs.
- rst = 0 during data bit 4 of 0x55 -> tx = 1 and busy = 0 after that edge. Release reset with FIFO holding 0x81 -> next frame carries 0x81, not the remainder of 0x55.
- CLKS_PER_BIT = 2, byte 0x01 -> each bit lasts 2 cycles, frame = 20 cycles, cnt never reaches 2.

Source files
------------

// File: rtl/uart_tx_drain.sv
// uart_tx_drain: pops bytes from a FIFO and sends each as an 8N1 UART frame, LSB first.
module uart_tx_drain #(
    parameter int CLKS_PER_BIT = 1250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_pop,
    output logic       tx,
    output logic       busy
);
    localparam int CNTW = $clog2(CLKS_PER_BIT);
    localparam logic [CNTW-1:0] CNT_MAX = CNTW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d, busy_q, busy_d, last;

    assign fifo_pop = rst & enable & ~fifo_empty & (state_q == IDLE);
    assign last     = cnt_q == CNT_MAX;
    assign tx       = tx_q;
    assign busy     = busy_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        if (state_q != IDLE) cnt_d = last ? '0 : cnt_q + CNTW'(1);
        case (state_q)
            IDLE: if (fifo_pop) begin
                shift_d = fifo_data;
                tx_d    = 1'b0;
                busy_d  = 1'b1;
                cnt_d   = '0;
                state_d = START;
            end
            START: if (last) begin
                tx_d    = shift_q[0];
                idx_d   = '0;
                state_d = DATA;
            end
            DATA: if (last) begin
                if (idx_q == 3'd7) begin
                    tx_d    = 1'b1;
                    state_d = STOP;
                end else begin
                    idx_d = idx_q + 3'd1;
                    tx_d  = shift_q[idx_d];
                end
            end
            STOP: if (last) begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end
endmodule
